mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_arb_req_slot.sv | 71 +++++++
 rtl/mem_port_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 544 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, request slot, port count.
// Slot fields are sized to the largest supported bus; modules cast to their own widths.
package mem_arb_pkg;

    localparam int unsigned NUM_PORTS  = 2;
    localparam int unsigned MAX_ADDR_W = 32;
    localparam int unsigned MAX_DATA_W = 64;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StIssue,
        StWait,
        StResp
    } arb_state_e;

    typedef struct packed {
        logic [MAX_ADDR_W-1:0] addr;
        logic [MAX_DATA_W-1:0] wdata;
        logic                  rws;
        logic                  pending;
    } req_slot_t;

endpackage

// File: rtl/mem_arb_req_slot.sv
// One requester slot: accept logic, request capture and response hold for a single port.
module mem_arb_req_slot
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned ADDRESS_WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [ADDRESS_WIDTH-1:0] address_i,
    input  logic                     address_valid_i,
    input  logic [DATA_WIDTH-1:0]    write_data_i,
    input  logic                     write_data_valid_i,
    input  logic                     read_write_select_i,
    input  logic                     complete_i,
    input  logic [DATA_WIDTH-1:0]    mem_read_data_i,
    input  logic                     release_i,
    output req_slot_t                slot_o,
    output logic [DATA_WIDTH-1:0]    read_data_o,
    output logic                     read_data_valid_o,
    output logic                     write_done_o,
    output logic                     port_ready_o
);

    req_slot_t             slot_q;
    logic [DATA_WIDTH-1:0] read_data_q;
    logic                  read_data_valid_q;
    logic                  write_done_q;
    logic                  accept;

    assign port_ready_o = !slot_q.pending;
    assign accept       = port_ready_o && address_valid_i &&
                          (!read_write_select_i || write_data_valid_i);

    // Responses become visible during RESP because completion is taken straight from WAIT.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            slot_q            <= '0;
            read_data_q       <= '0;
            read_data_valid_q <= 1'b0;
            write_done_q      <= 1'b0;
        end else begin
            write_done_q <= 1'b0;
            if (accept) begin
                slot_q.addr       <= MAX_ADDR_W'(address_i);
                slot_q.wdata      <= MAX_DATA_W'(write_data_i);
                slot_q.rws        <= read_write_select_i;
                slot_q.pending    <= 1'b1;
                read_data_valid_q <= 1'b0;
            end else begin
                if (complete_i) begin
                    if (slot_q.rws) begin
                        write_done_q <= 1'b1;
                    end else begin
                        read_data_valid_q <= 1'b1;
                        read_data_q       <= mem_read_data_i;
                    end
                end
                if (release_i) begin
                    slot_q.pending <= 1'b0;
                end
            end
        end
    end

    assign slot_o            = slot_q;
    assign read_data_o       = read_data_q;
    assign read_data_valid_o = read_data_valid_q;
    assign write_done_o      = write_done_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter onto a single memory port, one transaction in flight at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; otherwise port 0 has fixed priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned ADDRESS_WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [ADDRESS_WIDTH-1:0] fe_address_0_i,
    input  logic                     fe_address_valid_0_i,
    input  logic [DATA_WIDTH-1:0]    fe_write_data_0_i,
    input  logic                     fe_write_data_valid_0_i,
    input  logic                     fe_read_write_select_0_i,
    output logic [DATA_WIDTH-1:0]    fe_read_data_0_o,
    output logic                     fe_read_data_valid_0_o,
    output logic                     fe_write_done_0_o,
    output logic                     fe_port_ready_0_o,
    input  logic [ADDRESS_WIDTH-1:0] fe_address_1_i,
    input  logic                     fe_address_valid_1_i,
    input  logic [DATA_WIDTH-1:0]    fe_write_data_1_i,
    input  logic                     fe_write_data_valid_1_i,
    input  logic                     fe_read_write_select_1_i,
    output logic [DATA_WIDTH-1:0]    fe_read_data_1_o,
    output logic                     fe_read_data_valid_1_o,
    output logic                     fe_write_done_1_o,
    output logic                     fe_port_ready_1_o,
    output logic [ADDRESS_WIDTH-1:0] be_address_o,
    output logic                     be_address_valid_o,
    output logic [DATA_WIDTH-1:0]    be_write_data_o,
    output logic                     be_write_data_valid_o,
    output logic                     be_read_write_select_o,
    input  logic [DATA_WIDTH-1:0]    be_read_data_i,
    input  logic                     be_read_data_valid_i,
    input  logic                     be_write_done_i,
    input  logic                     be_port_ready_i
);

    arb_state_e               state_q;
    logic                     grant_q;
    logic [ADDRESS_WIDTH-1:0] be_address_q;
    logic                     be_address_valid_q;
    logic [DATA_WIDTH-1:0]    be_write_data_q;
    logic                     be_write_data_valid_q;
    logic                     be_rws_q;
`ifdef ARB_ROUND_ROBIN_EN
    logic                     last_grant_q;
`endif

    req_slot_t slot_0;
    req_slot_t slot_1;
    req_slot_t sel_slot;
    logic      winner;
    logic      mem_done;
    logic      complete_0, complete_1;
    logic      release_0, release_1;
    logic      unused_slot_bits;

    assign mem_done   = be_rws_q ? be_write_done_i : be_read_data_valid_i;
    assign complete_0 = (state_q == StWait) && mem_done && !grant_q;
    assign complete_1 = (state_q == StWait) && mem_done && grant_q;
    assign release_0  = (state_q == StResp) && !grant_q;
    assign release_1  = (state_q == StResp) && grant_q;

    always_comb begin
        winner = slot_1.pending && !slot_0.pending;
`ifdef ARB_ROUND_ROBIN_EN
        if (slot_0.pending && slot_1.pending) begin
            winner = !last_grant_q;
        end
`endif
    end

    assign sel_slot = winner ? slot_1 : slot_0;
    // Upper slot bits beyond the configured bus widths are always zero.
    assign unused_slot_bits = ^{slot_0, slot_1};

    mem_arb_req_slot #(
        .DATA_WIDTH   (DATA_WIDTH),
        .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_slot_0 (
        .clk_i              (clk_i),
        .reset_i            (reset_i),
        .address_i          (fe_address_0_i),
        .address_valid_i    (fe_address_valid_0_i),
        .write_data_i       (fe_write_data_0_i),
        .write_data_valid_i (fe_write_data_valid_0_i),
        .read_write_select_i(fe_read_write_select_0_i),
        .complete_i         (complete_0),
        .mem_read_data_i    (be_read_data_i),
        .release_i          (release_0),
        .slot_o             (slot_0),
        .read_data_o        (fe_read_data_0_o),
        .read_data_valid_o  (fe_read_data_valid_0_o),
        .write_done_o       (fe_write_done_0_o),
        .port_ready_o       (fe_port_ready_0_o)
    );

    mem_arb_req_slot #(
        .DATA_WIDTH   (DATA_WIDTH),
        .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_slot_1 (
        .clk_i              (clk_i),
        .reset_i            (reset_i),
        .address_i          (fe_address_1_i),
        .address_valid_i    (fe_address_valid_1_i),
        .write_data_i       (fe_write_data_1_i),
        .write_data_valid_i (fe_write_data_valid_1_i),
        .read_write_select_i(fe_read_write_select_1_i),
        .complete_i         (complete_1),
        .mem_read_data_i    (be_read_data_i),
        .release_i          (release_1),
        .slot_o             (slot_1),
        .read_data_o        (fe_read_data_1_o),
        .read_data_valid_o  (fe_read_data_valid_1_o),
        .write_done_o       (fe_write_done_1_o),
        .port_ready_o       (fe_port_ready_1_o)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q               <= StIdle;
            grant_q               <= 1'b0;
            be_address_q          <= '0;
            be_address_valid_q    <= 1'b0;
            be_write_data_q       <= '0;
            be_write_data_valid_q <= 1'b0;
            be_rws_q              <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q          <= 1'b1;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (slot_0.pending || slot_1.pending) begin
                        grant_q               <= winner;
                        be_address_q          <= sel_slot.addr[ADDRESS_WIDTH-1:0];
                        be_write_data_q       <= sel_slot.wdata[DATA_WIDTH-1:0];
                        be_rws_q              <= sel_slot.rws;
                        be_write_data_valid_q <= sel_slot.rws;
                        state_q               <= StReq;
                    end
                end
                StReq: begin
                    if (be_port_ready_i) begin
                        be_address_valid_q <= 1'b1;
                        state_q            <= StIssue;
                    end
                end
                StIssue: begin
                    be_address_valid_q <= 1'b0;
                    state_q            <= StWait;
                end
                StWait: begin
                    if (mem_done) begin
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    be_write_data_valid_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant_q          <= grant_q;
`endif
                    state_q               <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign be_address_o           = be_address_q;
    assign be_address_valid_o     = be_address_valid_q;
    assign be_write_data_o        = be_write_data_q;
    assign be_write_data_valid_o  = be_write_data_valid_q;
    assign be_read_write_select_o = be_rws_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a latency-modelled memory (read 9, write 14).
module tb_mem_port_arbiter;

    localparam int AW     = 8;
    localparam int DW     = 16;
    localparam int RD_LAT = 9;
    localparam int WR_LAT = 14;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0] a0 = '0, a1 = '0;
    logic          av0 = 1'b0, av1 = 1'b0;
    logic [DW-1:0] wd0 = '0, wd1 = '0;
    logic          wdv0 = 1'b0, wdv1 = 1'b0;
    logic          rws0 = 1'b0, rws1 = 1'b0;
    logic [DW-1:0] rd0, rd1;
    logic          rdv0, rdv1, wdn0, wdn1, rdy0, rdy1;
    logic [AW-1:0] be_a;
    logic          be_av, be_wdv, be_rws;
    logic [DW-1:0] be_wd;
    logic [DW-1:0] be_rd;
    logic          be_rdv, be_wdone;
    logic          be_rdy = 1'b1;

    mem_port_arbiter #(
        .DATA_WIDTH   (DW),
        .ADDRESS_WIDTH(AW)
    ) dut (
        .clk_i                   (clk),
        .reset_i                 (rst),
        .fe_address_0_i          (a0),
        .fe_address_valid_0_i    (av0),
        .fe_write_data_0_i       (wd0),
        .fe_write_data_valid_0_i (wdv0),
        .fe_read_write_select_0_i(rws0),
        .fe_read_data_0_o        (rd0),
        .fe_read_data_valid_0_o  (rdv0),
        .fe_write_done_0_o       (wdn0),
        .fe_port_ready_0_o       (rdy0),
        .fe_address_1_i          (a1),
        .fe_address_valid_1_i    (av1),
        .fe_write_data_1_i       (wd1),
        .fe_write_data_valid_1_i (wdv1),
        .fe_read_write_select_1_i(rws1),
        .fe_read_data_1_o        (rd1),
        .fe_read_data_valid_1_o  (rdv1),
        .fe_write_done_1_o       (wdn1),
        .fe_port_ready_1_o       (rdy1),
        .be_address_o            (be_a),
        .be_address_valid_o      (be_av),
        .be_write_data_o         (be_wd),
        .be_write_data_valid_o   (be_wdv),
        .be_read_write_select_o  (be_rws),
        .be_read_data_i          (be_rd),
        .be_read_data_valid_i    (be_rdv),
        .be_write_done_i         (be_wdone),
        .be_port_ready_i         (be_rdy)
    );

    // Memory model: accepts one address pulse, answers after a fixed latency.
    logic [DW-1:0] mem [256];
    logic          mm_busy;
    int            mm_cnt;
    logic          mm_w;
    logic [AW-1:0] mm_a;
    logic [DW-1:0] mm_d;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mm_busy    <= 1'b0;
            mm_cnt     <= 0;
            mm_w       <= 1'b0;
            mm_a       <= '0;
            mm_d       <= '0;
            be_rdv     <= 1'b0;
            be_wdone   <= 1'b0;
            be_rd      <= '0;
            mem[8'h01] <= 16'h1111;
            mem[8'h02] <= 16'h2222;
            mem[8'h12] <= 16'hBEEF;
        end else begin
            be_rdv   <= 1'b0;
            be_wdone <= 1'b0;
            if (!mm_busy && be_av) begin
                mm_busy <= 1'b1;
                mm_cnt  <= be_rws ? WR_LAT - 1 : RD_LAT - 1;
                mm_w    <= be_rws;
                mm_a    <= be_a;
                mm_d    <= be_wd;
            end else if (mm_busy) begin
                if (mm_cnt == 0) begin
                    mm_busy <= 1'b0;
                    if (mm_w) begin
                        mem[mm_a] <= mm_d;
                        be_wdone  <= 1'b1;
                    end else begin
                        be_rd  <= mem[mm_a];
                        be_rdv <= 1'b1;
                    end
                end else begin
                    mm_cnt <= mm_cnt - 1;
                end
            end
        end
    end

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          rws;
        logic          wdv;
    } iss_t;
    typedef struct {
        int            cyc;
        int            port;
        logic          wr;
        logic [DW-1:0] data;
    } resp_t;
    typedef struct {
        int            port;
        logic          wr;
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
    } exp_t;

    iss_t  iss_q[$];
    resp_t resp_q[$];
    exp_t  exp_q[$];

    int   cyc = 0;
    int   av_long = 0;
    int   wd_long = 0;
    logic p_av = 1'b0, p_rdv0 = 1'b0, p_rdv1 = 1'b0, p_wd0 = 1'b0, p_wd1 = 1'b0;
    int   vecs = 0;
    int   errs = 0;

    // Observation log: issue pulses and requester responses as they appear.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            p_av   <= 1'b0;
            p_rdv0 <= 1'b0;
            p_rdv1 <= 1'b0;
            p_wd0  <= 1'b0;
            p_wd1  <= 1'b0;
        end else begin
            if (be_av) begin
                iss_q.push_back('{cyc, be_a, be_wd, be_rws, be_wdv});
                if (p_av) av_long <= av_long + 1;
            end
            if (wdn0) begin
                resp_q.push_back('{cyc, 0, 1'b1, 16'h0000});
                if (p_wd0) wd_long <= wd_long + 1;
            end
            if (wdn1) begin
                resp_q.push_back('{cyc, 1, 1'b1, 16'h0000});
                if (p_wd1) wd_long <= wd_long + 1;
            end
            if (rdv0 && !p_rdv0) resp_q.push_back('{cyc, 0, 1'b0, rd0});
            if (rdv1 && !p_rdv1) resp_q.push_back('{cyc, 1, 1'b0, rd1});
            p_av   <= be_av;
            p_rdv0 <= rdv0;
            p_rdv1 <= rdv1;
            p_wd0  <= wdn0;
            p_wd1  <= wdn1;
        end
    end

    task automatic drive(input int port, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        if (port == 0) begin
            a0 = a; av0 = 1'b1; wd0 = d; wdv0 = w; rws0 = w;
        end else begin
            a1 = a; av1 = 1'b1; wd1 = d; wdv1 = w; rws1 = w;
        end
    endtask

    task automatic idle_inputs();
        av0 = 1'b0; wdv0 = 1'b0; rws0 = 1'b0;
        av1 = 1'b0; wdv1 = 1'b0; rws1 = 1'b0;
    endtask

    task automatic wait_resp(input int n, output bit timeout);
        int k = 0;
        while (resp_q.size() < n && k < 400) begin
            @(negedge clk);
            k++;
        end
        timeout = (resp_q.size() < n);
    endtask

    task automatic wait_issue(output bit timeout);
        int k = 0;
        while (!be_av && k < 50) begin
            @(negedge clk);
            k++;
        end
        timeout = !be_av;
    endtask

    task automatic test_reset();
        @(negedge clk);
        vecs++;
        if ({be_av, be_a, be_wd, be_wdv, be_rws} !== '0) begin
            errs++;
            $display("FAIL reset_be: got av %b a %h wd %h wdv %b rws %b, want all 0",
                     be_av, be_a, be_wd, be_wdv, be_rws);
        end
        vecs++;
        if ({rdy0, rdy1} !== 2'b11) begin
            errs++;
            $display("FAIL reset_ready: got %b%b, want 11", rdy0, rdy1);
        end
        vecs++;
        if ({rdv0, rdv1, wdn0, wdn1} !== 4'b0000) begin
            errs++;
            $display("FAIL reset_flags: got %b%b%b%b, want 0000", rdv0, rdv1, wdn0, wdn1);
        end
        vecs++;
        if ({rd0, rd1} !== '0) begin
            errs++;
            $display("FAIL reset_rdata: got %h %h, want 0 0", rd0, rd1);
        end
    endtask

    // Caller must be at a falling edge; both reads are presented together.
    task automatic test_tie(input string tag, input bit port1_first);
        bit    to;
        exp_t  e;
        resp_t r;
        iss_t  s;
        exp_q.delete(); resp_q.delete(); iss_q.delete();
        drive(0, 1'b0, 8'h01, '0);
        drive(1, 1'b0, 8'h02, '0);
        if (port1_first) begin
            exp_q.push_back('{1, 1'b0, 16'h2222, 8'h02});
            exp_q.push_back('{0, 1'b0, 16'h1111, 8'h01});
        end else begin
            exp_q.push_back('{0, 1'b0, 16'h1111, 8'h01});
            exp_q.push_back('{1, 1'b0, 16'h2222, 8'h02});
        end
        @(negedge clk);
        idle_inputs();
        vecs++;
        if ({rdy0, rdy1} !== 2'b00) begin
            errs++;
            $display("FAIL %s_accept: ready got %b%b, want 00", tag, rdy0, rdy1);
        end
        wait_resp(2, to);
        vecs++;
        if (to) begin
            errs++;
            $display("FAIL %s_timeout: got %0d responses, want 2", tag, resp_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                e = exp_q.pop_front();
                r = resp_q.pop_front();
                s = iss_q.pop_front();
                vecs++;
                if ({r.port[0], r.wr, r.data, s.addr} !== {e.port[0], e.wr, e.data, e.addr}) begin
                    errs++;
                    $display("FAIL %s[%0d]: got port %0d data %h addr %h, want port %0d data %h addr %h",
                             tag, i, r.port, r.data, s.addr, e.port, e.data, e.addr);
                end
            end
        end
    endtask

    task automatic test_read_p0();
        bit                 to;
        int                 lat = 0;
        logic [DW+1:0]      snap1;
        exp_t               e;
        resp_t              r;
        iss_t               s;
        @(negedge clk);
        exp_q.delete(); resp_q.delete(); iss_q.delete();
        snap1 = {rd1, rdv1, rdy1};
        drive(0, 1'b0, 8'h12, '0);
        exp_q.push_back('{0, 1'b0, 16'hBEEF, 8'h12});
        while (!be_av && lat < 20) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                idle_inputs();
                vecs++;
                if (rdv0 !== 1'b0) begin
                    errs++;
                    $display("FAIL read_p0_clear: rvalid0 got %b, want 0", rdv0);
                end
            end
        end
        vecs++;
        if (lat != 3) begin
            errs++;
            $display("FAIL read_p0_latency: got %0d cycles, want 3", lat);
        end
        wait_resp(1, to);
        vecs++;
        if (to) begin
            errs++;
            $display("FAIL read_p0_timeout: got %0d responses, want 1", resp_q.size());
        end else begin
            e = exp_q.pop_front();
            r = resp_q.pop_front();
            s = iss_q.pop_front();
            vecs++;
            if ({r.port[0], r.wr, r.data, s.addr} !== {e.port[0], e.wr, e.data, e.addr}) begin
                errs++;
                $display("FAIL read_p0: got port %0d data %h addr %h, want port %0d data %h addr %h",
                         r.port, r.data, s.addr, e.port, e.data, e.addr);
            end
        end
        vecs++;
        if (iss_q.size() != 0 || av_long != 0) begin
            errs++;
            $display("FAIL read_p0_pulse: extra pulses %0d long %0d, want 0 0",
                     iss_q.size(), av_long);
        end
        vecs++;
        if ({rd1, rdv1, rdy1} !== snap1) begin
            errs++;
            $display("FAIL read_p0_port1: got %h, want %h", {rd1, rdv1, rdy1}, snap1);
        end
        repeat (3) @(negedge clk);
        vecs++;
        if ({rdv0, rd0} !== {1'b1, 16'hBEEF}) begin
            errs++;
            $display("FAIL read_p0_hold: got %b %h, want 1 beef", rdv0, rd0);
        end
    endtask

    task automatic test_write_p1();
        bit    to;
        exp_t  e;
        resp_t r;
        iss_t  s;
        @(negedge clk);
        exp_q.delete(); resp_q.delete(); iss_q.delete();
        drive(1, 1'b1, 8'h40, 16'hA5A5);
        exp_q.push_back('{1, 1'b1, 16'h0000, 8'h40});
        @(negedge clk);
        idle_inputs();
        wait_resp(1, to);
        repeat (2) @(negedge clk);
        vecs++;
        if (to) begin
            errs++;
            $display("FAIL write_p1_timeout: got %0d responses, want 1", resp_q.size());
        end else begin
            e = exp_q.pop_front();
            r = resp_q.pop_front();
            s = iss_q.pop_front();
            vecs++;
            if ({r.port[0], r.wr, s.addr, s.wdata, s.rws, s.wdv} !==
                {e.port[0], e.wr, e.addr, 16'hA5A5, 1'b1, 1'b1}) begin
                errs++;
                $display("FAIL write_p1: got port %0d wr %b addr %h wd %h rws %b wdv %b, want 1 1 40 a5a5 1 1",
                         r.port, r.wr, s.addr, s.wdata, s.rws, s.wdv);
            end
        end
        vecs++;
        if (wd_long != 0 || resp_q.size() != 0) begin
            errs++;
            $display("FAIL write_p1_pulse: long %0d extra %0d, want 0 0", wd_long, resp_q.size());
        end
        drive(0, 1'b0, 8'h40, '0);
        exp_q.push_back('{0, 1'b0, 16'hA5A5, 8'h40});
        @(negedge clk);
        idle_inputs();
        wait_resp(1, to);
        vecs++;
        if (to) begin
            errs++;
            $display("FAIL readback_timeout: got %0d responses, want 1", resp_q.size());
        end else begin
            e = exp_q.pop_front();
            r = resp_q.pop_front();
            vecs++;
            if ({r.port[0], r.wr, r.data} !== {e.port[0], e.wr, e.data}) begin
                errs++;
                $display("FAIL readback: got port %0d data %h, want port %0d data %h",
                         r.port, r.data, e.port, e.data);
            end
        end
    endtask

    task automatic test_overlap();
        bit    to;
        exp_t  e0, e1;
        resp_t r0, r1;
        iss_t  s0, s1;
        @(negedge clk);
        exp_q.delete(); resp_q.delete(); iss_q.delete();
        drive(0, 1'b1, 8'h50, 16'h1234);
        exp_q.push_back('{0, 1'b1, 16'h0000, 8'h50});
        exp_q.push_back('{1, 1'b0, 16'hA5A5, 8'h40});
        @(negedge clk);
        idle_inputs();
        wait_issue(to);
        repeat (3) @(negedge clk);
        drive(1, 1'b0, 8'h40, '0);
        @(negedge clk);
        idle_inputs();
        vecs++;
        if (rdy1 !== 1'b0) begin
            errs++;
            $display("FAIL overlap_ready1: got %b, want 0", rdy1);
        end
        wait_resp(2, to);
        vecs++;
        if (to || iss_q.size() < 2) begin
            errs++;
            $display("FAIL overlap_timeout: got %0d responses %0d issues, want 2 2",
                     resp_q.size(), iss_q.size());
        end else begin
            e0 = exp_q.pop_front(); e1 = exp_q.pop_front();
            r0 = resp_q.pop_front(); r1 = resp_q.pop_front();
            s0 = iss_q.pop_front(); s1 = iss_q.pop_front();
            vecs++;
            if ({r0.port[0], r0.wr, s0.addr, r1.port[0], r1.wr, r1.data, s1.addr} !==
                {e0.port[0], e0.wr, e0.addr, e1.port[0], e1.wr, e1.data, e1.addr}) begin
                errs++;
                $display("FAIL overlap_order: got %0d/%b/%h then %0d/%b/%h/%h, want 0/1/50 then 1/0/a5a5/40",
                         r0.port, r0.wr, s0.addr, r1.port, r1.wr, r1.data, s1.addr);
            end
            vecs++;
            if (s1.cyc <= r0.cyc) begin
                errs++;
                $display("FAIL overlap_issue_after_done: issue cycle %0d, want after %0d",
                         s1.cyc, r0.cyc);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        @(negedge clk);
        exp_q.delete(); resp_q.delete(); iss_q.delete();
        // The request below is dropped by reset, so nothing is expected back.
        drive(0, 1'b0, 8'h12, '0);
        @(negedge clk);
        idle_inputs();
        wait_issue(to);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        vecs++;
        if ({be_av, be_a, be_wd, be_wdv, be_rws, rd0, rd1, rdv0, rdv1, wdn0, wdn1} !== '0 ||
            {rdy0, rdy1} !== 2'b11) begin
            errs++;
            $display("FAIL reset_mid: be %b %h %h %b %b fe %h %h %b%b%b%b rdy %b%b, want zeros rdy 11",
                     be_av, be_a, be_wd, be_wdv, be_rws, rd0, rd1, rdv0, rdv1, wdn0, wdn1,
                     rdy0, rdy1);
        end
        @(negedge clk);
        rst = 1'b0;
        resp_q.delete();
        repeat (30) @(negedge clk);
        vecs++;
        if (resp_q.size() != 0 || rdv0 !== 1'b0) begin
            errs++;
            $display("FAIL reset_mid_no_resp: got %0d responses rvalid0 %b, want 0 0",
                     resp_q.size(), rdv0);
        end
    endtask

    task automatic test_stall();
        bit    to;
        exp_t  e;
        resp_t r;
        @(negedge clk);
        exp_q.delete(); resp_q.delete(); iss_q.delete();
        be_rdy = 1'b0;
        drive(0, 1'b0, 8'h02, '0);
        exp_q.push_back('{0, 1'b0, 16'h2222, 8'h02});
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            vecs++;
            if ({be_a, be_av} !== {8'h02, 1'b0}) begin
                errs++;
                $display("FAIL stall[%0d]: got addr %h av %b, want 02 0", i, be_a, be_av);
            end
            @(negedge clk);
        end
        be_rdy = 1'b1;
        @(negedge clk);
        vecs++;
        if (be_av !== 1'b1) begin
            errs++;
            $display("FAIL stall_release: av got %b, want 1", be_av);
        end
        wait_resp(1, to);
        vecs++;
        if (to) begin
            errs++;
            $display("FAIL stall_timeout: got %0d responses, want 1", resp_q.size());
        end else begin
            e = exp_q.pop_front();
            r = resp_q.pop_front();
            vecs++;
            if ({r.port[0], r.data} !== {e.port[0], e.data}) begin
                errs++;
                $display("FAIL stall_data: got port %0d data %h, want port %0d data %h",
                         r.port, r.data, e.port, e.data);
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_tie("tie_after_reset", 1'b0);
        test_read_p0();
        // Port 0 was served last, so round-robin favours port 1 on this tie.
        @(negedge clk);
        test_tie("tie_second", RR);
        test_write_p1();
        test_overlap();
        test_reset_mid();
        test_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
